// File: rtl/bcd_time_counter_if.sv
// Control and display bus of the clock time-keeping core.
// Signals:
//   en, set_mode, inc_min, inc_hour   : controls into the time counter
//   min_lo, min_hi, hour_lo, hour_hi  : BCD digits HH:MM toward the digit mux
//   sec_tick, colon                   : 1 Hz tick pulse and colon segment enable
// master drives the controls and reads the display; slave is the counter itself.
interface bcd_time_counter_if;
  logic       en;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic [3:0] hour_lo;
  logic [3:0] hour_hi;
  logic       sec_tick;
  logic       colon;

  modport master (
    output en, set_mode, inc_min, inc_hour,
    input  min_lo, min_hi, hour_lo, hour_hi, sec_tick, colon
  );

  modport slave (
    input  en, set_mode, inc_min, inc_hour,
    output min_lo, min_hi, hour_lo, hour_hi, sec_tick, colon
  );
endinterface

// File: rtl/bcd_time_counter.sv
// Time-keeping core: 1 Hz prescaler, cascaded BCD seconds/minutes/hours,
// manual set mode and colon blink.
// Ports:
//   clk  : system clock, CLK_HZ cycles per second
//   rst  : synchronous active-high reset (time 00:00:00, colon on)
//   bus  : slave side of bcd_time_counter_if (controls in, digits/tick/colon out)
module bcd_time_counter #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  bcd_time_counter_if.slave   bus
);

  localparam int unsigned PW   = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

  logic [PW-1:0] presc, presc_n;
  logic [3:0]    sec_lo, sec_lo_n, sec_hi, sec_hi_n;
  logic [3:0]    min_lo, min_lo_n, min_hi, min_hi_n;
  logic [3:0]    hour_lo, hour_lo_n, hour_hi, hour_hi_n;
  logic          sec_tick, sec_tick_n;
  logic          colon, colon_n;

  logic tick_c, sec_carry_c, min_carry_c, min_step_c, hour_step_c;

  // Carry chain; in set mode the minute/hour steps come from the pulses instead
  always_comb begin
    tick_c      = bus.en && !bus.set_mode && (presc == TERM);
    sec_carry_c = tick_c && (sec_lo == 4'd9) && (sec_hi == 4'd5);
    min_carry_c = sec_carry_c && (min_lo == 4'd9) && (min_hi == 4'd5);
    min_step_c  = bus.set_mode ? bus.inc_min  : sec_carry_c;
    hour_step_c = bus.set_mode ? bus.inc_hour : min_carry_c;
  end

  // Next-state values for prescaler, digits, tick and colon
  always_comb begin
    presc_n    = presc;
    sec_lo_n   = sec_lo;
    sec_hi_n   = sec_hi;
    min_lo_n   = min_lo;
    min_hi_n   = min_hi;
    hour_lo_n  = hour_lo;
    hour_hi_n  = hour_hi;
    sec_tick_n = 1'b0;
    colon_n    = colon;

    if (bus.set_mode) begin
      presc_n  = '0;
      sec_lo_n = 4'd0;
      sec_hi_n = 4'd0;
      colon_n  = 1'b1;
    end else if (bus.en) begin
      presc_n    = tick_c ? '0 : presc + PW'(1);
      colon_n    = (presc_n < HALF);
      sec_tick_n = tick_c;
      if (tick_c) begin
        if (sec_lo == 4'd9) begin
          sec_lo_n = 4'd0;
          sec_hi_n = (sec_hi == 4'd5) ? 4'd0 : sec_hi + 4'd1;
        end else begin
          sec_lo_n = sec_lo + 4'd1;
        end
      end
    end

    // Minutes wrap 59 -> 00; the hour carry is handled separately
    if (min_step_c) begin
      if (min_lo == 4'd9) begin
        min_lo_n = 4'd0;
        min_hi_n = (min_hi == 4'd5) ? 4'd0 : min_hi + 4'd1;
      end else begin
        min_lo_n = min_lo + 4'd1;
      end
    end

    // Hours: 23 -> 00, otherwise units wrap 9 -> 0 into tens
    if (hour_step_c) begin
      if ((hour_hi == 4'd2) && (hour_lo == 4'd3)) begin
        hour_lo_n = 4'd0;
        hour_hi_n = 4'd0;
      end else if (hour_lo == 4'd9) begin
        hour_lo_n = 4'd0;
        hour_hi_n = hour_hi + 4'd1;
      end else begin
        hour_lo_n = hour_lo + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec_lo   <= 4'd0;
      sec_hi   <= 4'd0;
      min_lo   <= 4'd0;
      min_hi   <= 4'd0;
      hour_lo  <= 4'd0;
      hour_hi  <= 4'd0;
      sec_tick <= 1'b0;
      colon    <= 1'b1;
    end else begin
      presc    <= presc_n;
      sec_lo   <= sec_lo_n;
      sec_hi   <= sec_hi_n;
      min_lo   <= min_lo_n;
      min_hi   <= min_hi_n;
      hour_lo  <= hour_lo_n;
      hour_hi  <= hour_hi_n;
      sec_tick <= sec_tick_n;
      colon    <= colon_n;
    end
  end

  assign bus.min_lo   = min_lo;
  assign bus.min_hi   = min_hi;
  assign bus.hour_lo  = hour_lo;
  assign bus.hour_hi  = hour_hi;
  assign bus.sec_tick = sec_tick;
  assign bus.colon    = colon;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomized scoreboard bench for bcd_time_counter with a seconds-of-day model.
module tb_bcd_time_counter;

  localparam int unsigned CLK_HZ = 4;

  logic clk;
  logic rst;
  bcd_time_counter_if bus ();

  bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time as seconds since midnight plus a cycle counter
  int presc_m;
  int tsec_m;
  bit tick_m;
  bit colon_m;
  int cycle;

  int checks;
  int errors;
  logic [17:0] exp_q[$];

  task automatic model_update(input bit r, input bit e, input bit s,
                              input bit im, input bit ih);
    int h;
    int m;
    if (r) begin
      presc_m = 0; tsec_m = 0; tick_m = 1'b0; colon_m = 1'b1;
    end else if (s) begin
      h = tsec_m / 3600;
      m = (tsec_m / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      tsec_m  = h * 3600 + m * 60;
      presc_m = 0; tick_m = 1'b0; colon_m = 1'b1;
    end else if (e) begin
      if (presc_m == CLK_HZ - 1) begin
        presc_m = 0;
        tsec_m  = (tsec_m + 1) % 86400;
        tick_m  = 1'b1;
      end else begin
        presc_m = presc_m + 1;
        tick_m  = 1'b0;
      end
      colon_m = (presc_m < CLK_HZ / 2);
    end else begin
      tick_m = 1'b0;
    end
  endtask

  function automatic logic [17:0] expected();
    int h;
    int m;
    h = tsec_m / 3600;
    m = (tsec_m / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), tick_m, colon_m};
  endfunction

  // One clock of stimulus: drive at negedge, advance model, queue the response
  task automatic step(input bit r, input bit e, input bit s,
                      input bit im, input bit ih);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.set_mode = s;
    bus.inc_min  = im;
    bus.inc_hour = ih;
    model_update(r, e, s, im, ih);
    exp_q.push_back(expected());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Enter set mode and pulse inc_hour/inc_min until the model shows hh:mm
  task automatic set_time(input int hh, input int mm);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    while (tsec_m / 3600 != hh) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    while ((tsec_m / 60) % 60 != mm) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Monitor: every clock the DUT presents a fresh output word
  always @(posedge clk) begin
    logic [17:0] act;
    logic [17:0] exp;
    #1;
    cycle = cycle + 1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.hour_hi, bus.hour_lo, bus.min_hi, bus.min_lo, bus.sec_tick, bus.colon};
      checks = checks + 1;
      if (act !== exp) begin
        errors = errors + 1;
        $display("FAIL outputs cycle %0d: got %0h%0h:%0h%0h tick=%0b colon=%0b, expected %0h%0h:%0h%0h tick=%0b colon=%0b",
                 cycle, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                 exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
    end
  end

  initial begin
    bit sm;
    checks = 0; errors = 0; cycle = 0;
    presc_m = 0; tsec_m = 0; tick_m = 1'b0; colon_m = 1'b1;
    rst = 1'b1;
    bus.en = 1'b0; bus.set_mode = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;

    // Reset, tick cadence and first minute carry
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(250);

    // Full rollover 23:59:59 -> 00:00:00
    set_time(23, 59);
    run(60 * CLK_HZ + 6);

    // 00:59 plus 10 minute pulses -> 00:09
    set_time(0, 59);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 21 plus 5 hour pulses -> 02
    set_time(21, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Simultaneous pulses from 09:59 -> 10:00
    set_time(9, 59);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Leave set mode, freeze with en=0, and ignored pulses while counting
    run(7);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run(5);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset mid-prescale at 12:34 with inc_hour asserted
    set_time(12, 34);
    run(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(10);

    // Randomized traffic
    sm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) sm = ~sm;
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 9) != 0),
           sm,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d responses still queued, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
